// File: rtl/cfs_apb_irq_ctrl_if.sv
// APB slave bus bundle for the interrupt-controller register block.
interface cfs_apb_irq_ctrl_if #(
  parameter int APB_ADDR_WIDTH = 16
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [31:0]               pwdata;
  logic                      pready;
  logic [31:0]               prdata;
  logic                      pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/cfs_apb_irq_ctrl.sv
// Parametrised APB interrupt controller: edge/level sources, sticky W1C status,
// per-source enable, saturating event counter, programmable wait states.
//
// state | meaning
// IDLE  | waiting for psel&penable (re-armed only after the access drops)
// WAIT  | counting down wait states, access must stay asserted
// RESP  | pready high for one cycle with registered prdata/pslverr
module cfs_apb_irq_ctrl #(
  parameter int                APB_ADDR_WIDTH = 16,
  parameter int                N_IRQ          = 8,
  parameter int                WAIT_STATES    = 0,
  parameter int                CNT_WIDTH      = 16,
  parameter logic [N_IRQ-1:0]  SRC_RESET_VAL  = '0
) (
  input  logic                 pclk,
  input  logic                 presetn,
  cfs_apb_irq_ctrl_if.slave    apb,
  input  logic [N_IRQ-1:0]     irq_src,
  output logic [N_IRQ-1:0]     irq_stat,
  output logic                 irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0]           WS      = 4'(WAIT_STATES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic                 hold_q;
  logic                 access;
  logic                 commit;

  logic                 addr_hi_ok;
  logic [2:0]           word;
  logic                 sel_en, sel_mode, sel_stat, sel_raw, sel_cnt;
  logic                 addr_ok;
  logic                 acc_err;
  logic                 wr_commit;
  logic [31:0]          rdata_d;
  logic [31:0]          prdata_q;
  logic                 pslverr_q;

  logic [N_IRQ-1:0]     irqen_q, irqen_d;
  logic [N_IRQ-1:0]     mode_q, mode_d;
  logic [N_IRQ-1:0]     stat_q, stat_d;
  logic [N_IRQ-1:0]     src_q;
  logic [N_IRQ-1:0]     set_v;
  logic [N_IRQ-1:0]     w1c;
  logic                 stat_rise;
  logic [CNT_WIDTH-1:0] evcnt_q, evcnt_d;
  logic                 irq_q;

  logic                 unused_bits;
  assign unused_bits = ^{apb.paddr[1:0], apb.pwdata};

  assign access = apb.psel & apb.penable;

  // FSM: next state, wait counter and the commit strobe for side effects
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access && !hold_q) begin
          wcnt_d = WS;
          if (WS == 4'd0) begin
            commit  = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!access) begin
          state_d = ST_IDLE;
        end else if (wcnt_q <= 4'd1) begin
          commit  = 1'b1;
          state_d = ST_RESP;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_q == ST_RESP)
        hold_q <= 1'b1;
      else if (!access)
        hold_q <= 1'b0;
    end
  end

  // Address decode
  assign addr_hi_ok = (apb.paddr[APB_ADDR_WIDTH-1:5] == '0);
  assign word       = apb.paddr[4:2];
  assign sel_en     = addr_hi_ok && (word == 3'd0);
  assign sel_mode   = addr_hi_ok && (word == 3'd1);
  assign sel_stat   = addr_hi_ok && (word == 3'd2);
  assign sel_raw    = addr_hi_ok && (word == 3'd3);
  assign sel_cnt    = addr_hi_ok && (word == 3'd4);
  assign addr_ok    = addr_hi_ok && (word <= 3'd4);
  assign acc_err    = !addr_ok || (apb.pwrite && sel_raw);
  assign wr_commit  = commit & apb.pwrite;

  always_comb begin
    rdata_d = '0;
    if (!apb.pwrite) begin
      if (sel_en)   rdata_d[N_IRQ-1:0]     = irqen_q;
      if (sel_mode) rdata_d[N_IRQ-1:0]     = mode_q;
      if (sel_stat) rdata_d[N_IRQ-1:0]     = stat_q;
      if (sel_raw)  rdata_d[N_IRQ-1:0]     = irq_src;
      if (sel_cnt)  rdata_d[CNT_WIDTH-1:0] = evcnt_q;
    end
  end

  // Response registers only carry data in the RESP cycle
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      prdata_q  <= commit ? rdata_d : '0;
      pslverr_q <= commit & acc_err;
    end
  end

  assign apb.pready  = (state_q == ST_RESP);
  assign apb.prdata  = prdata_q;
  assign apb.pslverr = pslverr_q;

  // Interrupt source, status and counter logic
  always_comb begin
    irqen_d   = (wr_commit && sel_en)   ? apb.pwdata[N_IRQ-1:0] : irqen_q;
    mode_d    = (wr_commit && sel_mode) ? apb.pwdata[N_IRQ-1:0] : mode_q;
    w1c       = (wr_commit && sel_stat) ? apb.pwdata[N_IRQ-1:0] : '0;
    set_v     = irq_src & (mode_q | ~src_q);
    stat_d    = set_v | (stat_q & ~w1c);
    stat_rise = |(stat_d & ~stat_q);
  end

  // A clear that coincides with a new event keeps that event
  always_comb begin
    evcnt_d = evcnt_q;
    if (wr_commit && sel_cnt)
      evcnt_d = stat_rise ? CNT_ONE : '0;
    else if (stat_rise && (evcnt_q != CNT_MAX))
      evcnt_d = evcnt_q + CNT_ONE;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irqen_q <= '0;
      mode_q  <= '0;
      stat_q  <= '0;
      src_q   <= SRC_RESET_VAL;
      evcnt_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      irqen_q <= irqen_d;
      mode_q  <= mode_d;
      stat_q  <= stat_d;
      src_q   <= irq_src;
      evcnt_q <= evcnt_d;
      irq_q   <= |(stat_d & irqen_d);
    end
  end

  assign irq_stat = stat_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_cfs_apb_irq_ctrl.sv
// Directed bench: dut_a has no wait states and a 2-bit counter, dut_b has 3 wait states.
module tb_cfs_apb_irq_ctrl;
  localparam int AW = 16;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [7:0] src_a, src_b;
  logic [7:0] stat_a, stat_b;
  logic       irq_a, irq_b;

  always #5 pclk = ~pclk;

  cfs_apb_irq_ctrl_if #(.APB_ADDR_WIDTH(AW)) bus_a ();
  cfs_apb_irq_ctrl_if #(.APB_ADDR_WIDTH(AW)) bus_b ();

  cfs_apb_irq_ctrl #(.APB_ADDR_WIDTH(AW), .N_IRQ(8), .WAIT_STATES(0), .CNT_WIDTH(2)) dut_a (
    .pclk(pclk), .presetn(presetn), .apb(bus_a.slave),
    .irq_src(src_a), .irq_stat(stat_a), .irq(irq_a)
  );

  cfs_apb_irq_ctrl #(.APB_ADDR_WIDTH(AW), .N_IRQ(8), .WAIT_STATES(3), .CNT_WIDTH(16)) dut_b (
    .pclk(pclk), .presetn(presetn), .apb(bus_b.slave),
    .irq_src(src_b), .irq_stat(stat_b), .irq(irq_b)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_bus(input bit b, input logic s, input logic e, input logic w,
                         input logic [15:0] a, input logic [31:0] d);
    if (b) begin
      bus_b.psel = s; bus_b.penable = e; bus_b.pwrite = w; bus_b.paddr = a; bus_b.pwdata = d;
    end else begin
      bus_a.psel = s; bus_a.penable = e; bus_a.pwrite = w; bus_a.paddr = a; bus_a.pwdata = d;
    end
  endtask

  task automatic src_or(input bit b, input logic [7:0] m);
    if (b) src_b = src_b | m; else src_a = src_a | m;
  endtask

  task automatic src_clr(input bit b, input logic [7:0] m);
    if (b) src_b = src_b & ~m; else src_a = src_a & ~m;
  endtask

  // One APB transfer. lat = negedges after penable rose until pready (-1 on timeout).
  // pmask is pulsed on the chosen DUT's sources during negedge interval pulse_at.
  task automatic apb(input bit b, input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                     input int pulse_at, input logic [7:0] pmask, input bit hold,
                     output logic [31:0] rd, output logic err, output int lat, output logic p_after);
    logic pr;
    rd = '0; err = 1'b0; lat = -1; p_after = 1'b0;
    @(negedge pclk);
    set_bus(b, 1'b1, 1'b0, wr, addr, wd);
    @(negedge pclk);
    set_bus(b, 1'b1, 1'b1, wr, addr, wd);
    if (pulse_at == 0) src_or(b, pmask);
    for (int k = 1; k <= 40; k++) begin
      @(negedge pclk);
      pr = b ? bus_b.pready : bus_a.pready;
      if (k == pulse_at + 1) src_clr(b, pmask);
      if (k == pulse_at)     src_or(b, pmask);
      if (pr) begin
        rd  = b ? bus_b.prdata  : bus_a.prdata;
        err = b ? bus_b.pslverr : bus_a.pslverr;
        lat = k;
        break;
      end
    end
    if (hold) begin
      @(negedge pclk);
      p_after = b ? bus_b.pready : bus_a.pready;
    end
    set_bus(b, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    src_clr(b, pmask);
  endtask

  task automatic xfer(input string name, input bit b, input bit wr, input logic [15:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] rd;
    logic        err, pa;
    int          lat;
    apb(b, wr, addr, wd, -5, 8'h00, 1'b0, rd, err, lat, pa);
    chk({name, "_lat"}, 32'(lat), b ? 32'd4 : 32'd1);
    chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    if (!wr) chk({name, "_rd"}, rd, exp_rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err, pa, seen;
    int          lat;

    vt[0]  = '{0, 16'h0000, 32'h0,        32'h0,  0};
    vt[1]  = '{0, 16'h0004, 32'h0,        32'h0,  0};
    vt[2]  = '{0, 16'h0008, 32'h0,        32'h0,  0};
    vt[3]  = '{0, 16'h000C, 32'h0,        32'h0,  0};
    vt[4]  = '{0, 16'h0010, 32'h0,        32'h0,  0};
    vt[5]  = '{1, 16'h0000, 32'h0000_00A5, 32'h0, 0};
    vt[6]  = '{0, 16'h0000, 32'h0,        32'hA5, 0};
    vt[7]  = '{1, 16'h0000, 32'hFFFF_F1FF, 32'h0, 0};
    vt[8]  = '{0, 16'h0000, 32'h0,        32'hFF, 0};
    vt[9]  = '{1, 16'h000C, 32'h1,        32'h0,  1};
    vt[10] = '{0, 16'h0014, 32'h0,        32'h0,  1};
    vt[11] = '{0, 16'h0100, 32'h0,        32'h0,  1};
    vt[12] = '{1, 16'h0014, 32'h5,        32'h0,  1};
    vt[13] = '{1, 16'h0004, 32'h3C,       32'h0,  0};
    vt[14] = '{0, 16'h0004, 32'h0,        32'h3C, 0};
    vt[15] = '{0, 16'h0007, 32'h0,        32'h3C, 0};
    vt[16] = '{1, 16'h0004, 32'h0,        32'h0,  0};
    vt[17] = '{1, 16'h0000, 32'h0,        32'h0,  0};
    vt[18] = '{0, 16'h000E, 32'h0,        32'h0,  0};
    vt[19] = '{1, 16'h0010, 32'hFFFF,     32'h0,  0};

    presetn = 1'b0;
    src_a = 8'h00; src_b = 8'h00;
    set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    set_bus(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (3) @(negedge pclk);
    chk("rst_pready_a",  {31'd0, bus_a.pready},  32'd0);
    chk("rst_prdata_a",  bus_a.prdata,           32'd0);
    chk("rst_pslverr_a", {31'd0, bus_a.pslverr}, 32'd0);
    chk("rst_stat_a",    {24'd0, stat_a},        32'd0);
    chk("rst_irq_a",     {31'd0, irq_a},         32'd0);
    chk("rst_pready_b",  {31'd0, bus_b.pready},  32'd0);
    presetn = 1'b1;
    @(negedge pclk);

    for (int i = 0; i < 20; i++)
      xfer($sformatf("vec%0d", i), 1'b0, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].exp_rd, vt[i].exp_err);

    // Access held after pready must not start a second transfer
    apb(1'b0, 1'b0, 16'h0000, 32'h0, -5, 8'h00, 1'b1, rd, err, lat, pa);
    chk("hold_lat", 32'(lat), 32'd1);
    chk("hold_no_retrigger", {31'd0, pa}, 32'd0);

    // Edge mode, source 2
    xfer("edge_en", 1'b0, 1'b1, 16'h0000, 32'h04, 32'h0, 1'b0);
    @(negedge pclk);
    src_a[2] = 1'b1;
    chk("edge_irq_before", {31'd0, irq_a}, 32'd0);
    @(negedge pclk);
    src_a[2] = 1'b0;
    chk("edge_stat", {24'd0, stat_a}, 32'h04);
    chk("edge_irq",  {31'd0, irq_a},  32'd1);
    xfer("edge_rd_stat", 1'b0, 1'b0, 16'h0008, 32'h0, 32'h04, 1'b0);
    xfer("edge_w1c", 1'b0, 1'b1, 16'h0008, 32'h04, 32'h0, 1'b0);
    chk("edge_stat_clr", {24'd0, stat_a}, 32'h00);
    chk("edge_irq_clr",  {31'd0, irq_a},  32'd0);

    // Level mode, source 0 held high
    xfer("lvl_mode", 1'b0, 1'b1, 16'h0004, 32'h01, 32'h0, 1'b0);
    @(negedge pclk);
    src_a[0] = 1'b1;
    @(negedge pclk);
    chk("lvl_stat_set", {24'd0, stat_a}, 32'h01);
    xfer("lvl_w1c_high", 1'b0, 1'b1, 16'h0008, 32'h01, 32'h0, 1'b0);
    chk("lvl_stat_stays", {24'd0, stat_a}, 32'h01);
    src_a[0] = 1'b0;
    @(negedge pclk);
    xfer("lvl_w1c_low", 1'b0, 1'b1, 16'h0008, 32'h01, 32'h0, 1'b0);
    chk("lvl_stat_clr", {24'd0, stat_a}, 32'h00);
    xfer("lvl_mode_off", 1'b0, 1'b1, 16'h0004, 32'h00, 32'h0, 1'b0);

    // 2-bit counter saturation, then clear coincident with an event
    xfer("cnt_clr", 1'b0, 1'b1, 16'h0010, 32'h0, 32'h0, 1'b0);
    xfer("cnt_rd0", 1'b0, 1'b0, 16'h0010, 32'h0, 32'h0, 1'b0);
    for (int i = 3; i < 8; i++) begin
      @(negedge pclk);
      src_a[i] = 1'b1;
      @(negedge pclk);
      src_a[i] = 1'b0;
    end
    @(negedge pclk);
    chk("cnt_stat", {24'd0, stat_a}, 32'hF8);
    xfer("cnt_sat", 1'b0, 1'b0, 16'h0010, 32'h0, 32'd3, 1'b0);
    apb(1'b0, 1'b1, 16'h0010, 32'h0, 0, 8'h04, 1'b0, rd, err, lat, pa);
    chk("cnt_clr_evt_lat", 32'(lat), 32'd1);
    chk("cnt_clr_evt_stat", {24'd0, stat_a}, 32'hFC);
    xfer("cnt_clr_evt", 1'b0, 1'b0, 16'h0010, 32'h0, 32'd1, 1'b0);

    // Wait-state DUT
    xfer("ws_wr_en", 1'b1, 1'b1, 16'h0000, 32'hFF, 32'h0, 1'b0);
    xfer("ws_rd_en", 1'b1, 1'b0, 16'h0000, 32'h0, 32'hFF, 1'b0);
    xfer("ws_wr_raw", 1'b1, 1'b1, 16'h000C, 32'h1, 32'h0, 1'b1);

    // Abort during wait states: no pready, no write
    @(negedge pclk);
    set_bus(1, 1'b1, 1'b0, 1'b1, 16'h0000, 32'h0F);
    @(negedge pclk);
    set_bus(1, 1'b1, 1'b1, 1'b1, 16'h0000, 32'h0F);
    seen = 1'b0;
    repeat (2) begin
      @(negedge pclk);
      seen = seen | bus_b.pready;
    end
    set_bus(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (5) begin
      @(negedge pclk);
      seen = seen | bus_b.pready;
    end
    chk("abort_no_pready", {31'd0, seen}, 32'd0);
    xfer("abort_no_write", 1'b1, 1'b0, 16'h0000, 32'h0, 32'hFF, 1'b0);

    // Edge on src[1] at the W1C commit edge of bit 1
    xfer("co_cnt_clr", 1'b1, 1'b1, 16'h0010, 32'h0, 32'h0, 1'b0);
    apb(1'b1, 1'b1, 16'h0008, 32'h02, 3, 8'h02, 1'b0, rd, err, lat, pa);
    chk("co_lat", 32'(lat), 32'd4);
    chk("co_stat", {24'd0, stat_b}, 32'h02);
    chk("co_irq", {31'd0, irq_b}, 32'd1);
    xfer("co_cnt", 1'b1, 1'b0, 16'h0010, 32'h0, 32'd1, 1'b0);
    apb(1'b1, 1'b1, 16'h0008, 32'h02, 3, 8'h02, 1'b0, rd, err, lat, pa);
    chk("co_set_wins", {24'd0, stat_b}, 32'h02);

    // Reset in the middle of a wait-state transfer
    @(negedge pclk);
    set_bus(1, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h0);
    @(negedge pclk);
    set_bus(1, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0);
    repeat (2) @(negedge pclk);
    presetn = 1'b0;
    #1;
    chk("midrst_pready", {31'd0, bus_b.pready}, 32'd0);
    chk("midrst_stat",   {24'd0, stat_b},       32'd0);
    chk("midrst_irq",    {31'd0, irq_b},        32'd0);
    set_bus(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge pclk);
    presetn = 1'b1;
    xfer("midrst_en", 1'b1, 1'b0, 16'h0000, 32'h0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
